// File: rtl/mvm_noc_inject_arb_if.sv
// Stream bundle for mvm_noc_inject_arb: the requester-side AXI-Stream lanes,
// the single NoC injection stream and the arbiter status outputs.
interface mvm_noc_inject_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int DATAW   = 512,
  parameter int IDW     = 8,
  parameter int DESTW   = 8,
  parameter int USERW   = 8
);
  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       S_TVALID;
  logic [NUM_REQ-1:0]       S_TREADY;
  logic [NUM_REQ*DATAW-1:0] S_TDATA;
  logic [NUM_REQ-1:0]       S_TLAST;
  logic [NUM_REQ*IDW-1:0]   S_TID;
  logic [NUM_REQ*DESTW-1:0] S_TDEST;
  logic [NUM_REQ*USERW-1:0] S_TUSER;

  logic             M_TVALID;
  logic             M_TREADY;
  logic [DATAW-1:0] M_TDATA;
  logic             M_TLAST;
  logic [IDW-1:0]   M_TID;
  logic [DESTW-1:0] M_TDEST;
  logic [USERW-1:0] M_TUSER;

  logic [IDXW-1:0]  GRANT_IDX;
  logic             BUSY;
  logic [15:0]      PKT_CNT;

  // Arbiter view: accepts requester lanes, drives the injection stream and status.
  modport master (
    input  S_TVALID, S_TDATA, S_TLAST, S_TID, S_TDEST, S_TUSER, M_TREADY,
    output S_TREADY, M_TVALID, M_TDATA, M_TLAST, M_TID, M_TDEST, M_TUSER,
    output GRANT_IDX, BUSY, PKT_CNT
  );

  // Environment view: the requesters plus the NoC injection port.
  modport slave (
    output S_TVALID, S_TDATA, S_TLAST, S_TID, S_TDEST, S_TUSER, M_TREADY,
    input  S_TREADY, M_TVALID, M_TDATA, M_TLAST, M_TID, M_TDEST, M_TUSER,
    input  GRANT_IDX, BUSY, PKT_CNT
  );
endinterface

// File: rtl/mvm_noc_inject_arb.sv
// Packet-granular round-robin arbiter that merges NUM_REQ AXI-Stream
// requesters into one NoC injection port through a single output register.
module mvm_noc_inject_arb #(
  parameter int NUM_REQ = 4,
  parameter int DATAW   = 512,
  parameter int IDW     = 8,
  parameter int DESTW   = 8,
  parameter int USERW   = 8
) (
  input logic                  CLK,
  input logic                  RST_N,
  mvm_noc_inject_arb_if.master bus
);
  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, LOCKED} state_e;

  typedef struct packed {
    logic [DATAW-1:0] data;
    logic             last;
    logic [IDW-1:0]   id;
    logic [DESTW-1:0] dest;
    logic [USERW-1:0] user;
  } beat_t;

  state_e          state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] grantIdx_q, grantIdx_d;
  logic [15:0]     pktCnt_q, pktCnt_d;
  logic            mValid_q, mValid_d;
  beat_t           payload_q, payload_d;

  logic [IDXW-1:0]    winner;
  logic               anyValid;
  logic               outFree;
  logic               load;
  logic               lastHs;
  logic [NUM_REQ-1:0] sReady;

  // Round-robin search: first valid requester at or above ptr, wrapping round.
  always_comb begin
    winner   = ptr_q;
    anyValid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int cand;
      cand = int'(ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!anyValid && bus.S_TVALID[IDXW'(cand)]) begin
        anyValid = 1'b1;
        winner   = IDXW'(cand);
      end
    end
  end

  // Grant FSM, ready generation and output-register next state.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grantIdx_d = grantIdx_q;
    pktCnt_d   = pktCnt_q;
    mValid_d   = mValid_q;
    payload_d  = payload_q;
    sReady     = '0;
    outFree    = !mValid_q || bus.M_TREADY;
    load       = 1'b0;
    lastHs     = 1'b0;
    case (state_q)
      IDLE: begin
        if (anyValid) begin
          state_d    = LOCKED;
          grantIdx_d = winner;
        end
      end
      LOCKED: begin
        sReady[grantIdx_q] = outFree;
        load   = outFree && bus.S_TVALID[grantIdx_q];
        lastHs = load && bus.S_TLAST[grantIdx_q];
        if (lastHs) begin
          state_d  = IDLE;
          ptr_d    = (grantIdx_q == IDXW'(NUM_REQ - 1)) ? '0 : grantIdx_q + 1'b1;
          pktCnt_d = pktCnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      mValid_d       = 1'b1;
      payload_d.data = bus.S_TDATA[grantIdx_q*DATAW +: DATAW];
      payload_d.last = bus.S_TLAST[grantIdx_q];
      payload_d.id   = bus.S_TID[grantIdx_q*IDW +: IDW];
      payload_d.dest = bus.S_TDEST[grantIdx_q*DESTW +: DESTW];
      payload_d.user = bus.S_TUSER[grantIdx_q*USERW +: USERW];
    end else if (bus.M_TREADY) begin
      mValid_d = 1'b0;
    end
  end

  // State and output register; reset drops any packet and held beat.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grantIdx_q <= '0;
      pktCnt_q   <= '0;
      mValid_q   <= 1'b0;
      payload_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grantIdx_q <= grantIdx_d;
      pktCnt_q   <= pktCnt_d;
      mValid_q   <= mValid_d;
      payload_q  <= payload_d;
    end
  end

  assign bus.S_TREADY  = sReady;
  assign bus.M_TVALID  = mValid_q;
  assign bus.M_TDATA   = payload_q.data;
  assign bus.M_TLAST   = payload_q.last;
  assign bus.M_TID     = payload_q.id;
  assign bus.M_TDEST   = payload_q.dest;
  assign bus.M_TUSER   = payload_q.user;
  assign bus.GRANT_IDX = grantIdx_q;
  assign bus.BUSY      = (state_q == LOCKED);
  assign bus.PKT_CNT   = pktCnt_q;
endmodule

// File: tb/tb_mvm_noc_inject_arb.sv
// Self-checking bench for mvm_noc_inject_arb: directed scenarios plus random
// traffic, all checked against a queue-based packet-level reference model.
module tb_mvm_noc_inject_arb;
  localparam int NUM_REQ = 4;
  localparam int DATAW   = 512;
  localparam int IDW     = 8;
  localparam int DESTW   = 8;
  localparam int USERW   = 8;

  typedef logic [511:0] wide_t;
  typedef struct {
    logic [DATAW-1:0] data;
    logic             last;
    logic [IDW-1:0]   id;
    logic [DESTW-1:0] dest;
    logic [USERW-1:0] user;
  } beat_t;

  logic clk = 1'b0;
  logic rstN;

  mvm_noc_inject_arb_if #(.NUM_REQ(NUM_REQ), .DATAW(DATAW), .IDW(IDW), .DESTW(DESTW), .USERW(USERW)) bus ();
  mvm_noc_inject_arb #(.NUM_REQ(NUM_REQ), .DATAW(DATAW), .IDW(IDW), .DESTW(DESTW), .USERW(USERW)) dut (
    .CLK(clk), .RST_N(rstN), .bus(bus)
  );

  always #5 clk = ~clk;

  int testCount = 0;
  int failCount = 0;
  int cyc = 0;

  // Reference model: pending beats per requester, the one-deep output stage,
  // and packet-level arbitration state.
  beat_t       srcQ[NUM_REQ][$];
  beat_t       outQ[$];
  bit          expBusy = 1'b0;
  int          expGrant = 0;
  int          expPtr = 0;
  logic [15:0] expPktCnt = '0;
  int          inHsCount = 0;

  // Observations taken from the DUT.
  beat_t outLog[$];
  int    outCyc[$];
  int    grantLog[$];
  bit    prevBusy = 1'b0;

  // Stimulus knobs.
  int               vldPct = 100;
  int               rdyPct = 100;
  logic [NUM_REQ-1:0] holdLow = '0;
  bit               rdyLow = 1'b0;
  bit               rstReq = 1'b0;

  // Count one comparison and report it when observed differs from expected.
  task automatic checkOutput(input string tag, input wide_t obs, input wide_t exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Queue one packet on requester r; data counts up from base unless randomised.
  task automatic addPacket(input int r, input int len, input int base, input bit rnd);
    for (int k = 0; k < len; k++) begin
      beat_t b;
      b.data = DATAW'(base + k);
      if (rnd) for (int w = 0; w < DATAW / 32; w++) b.data[w*32 +: 32] = $urandom();
      b.last = (k == len - 1);
      b.id   = IDW'(r);
      b.dest = DESTW'($urandom_range(255));
      b.user = USERW'($urandom_range(255));
      srcQ[r].push_back(b);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i < NUM_REQ; i++) srcQ[i].delete();
    outQ.delete();
    expBusy   = 1'b0;
    expGrant  = 0;
    expPtr    = 0;
    expPktCnt = '0;
    prevBusy  = 1'b0;
  endfunction

  function automatic bit pending();
    bit p;
    p = expBusy || (outQ.size() != 0);
    for (int i = 0; i < NUM_REQ; i++) if (srcQ[i].size() != 0) p = 1'b1;
    return p;
  endfunction

  function automatic void clearLogs();
    outLog.delete();
    outCyc.delete();
    grantLog.delete();
  endfunction

  // One clock cycle: drive at negedge, check and advance the model just before posedge.
  task automatic applyStimulus();
    logic [NUM_REQ-1:0] expRdy;
    bit inHs, outHs;
    int win;
    @(negedge clk);
    rstN = !rstReq;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.S_TVALID[i] = (srcQ[i].size() != 0) && !holdLow[i] && ($urandom_range(99) < vldPct);
      if (srcQ[i].size() != 0) begin
        bus.S_TDATA[i*DATAW +: DATAW] = srcQ[i][0].data;
        bus.S_TLAST[i]                = srcQ[i][0].last;
        bus.S_TID[i*IDW +: IDW]       = srcQ[i][0].id;
        bus.S_TDEST[i*DESTW +: DESTW] = srcQ[i][0].dest;
        bus.S_TUSER[i*USERW +: USERW] = srcQ[i][0].user;
      end else begin
        bus.S_TDATA[i*DATAW +: DATAW] = '0;
        bus.S_TLAST[i]                = 1'b0;
        bus.S_TID[i*IDW +: IDW]       = '0;
        bus.S_TDEST[i*DESTW +: DESTW] = '0;
        bus.S_TUSER[i*USERW +: USERW] = '0;
      end
    end
    bus.M_TREADY = !rdyLow && ($urandom_range(99) < rdyPct);
    #4;
    cyc++;
    if (bus.BUSY && !prevBusy) grantLog.push_back(int'(bus.GRANT_IDX));
    prevBusy = bus.BUSY;
    if (bus.M_TVALID && bus.M_TREADY) begin
      beat_t o;
      o.data = bus.M_TDATA; o.last = bus.M_TLAST; o.id = bus.M_TID;
      o.dest = bus.M_TDEST; o.user = bus.M_TUSER;
      outLog.push_back(o);
      outCyc.push_back(cyc);
    end
    checkOutput("busy", wide_t'(bus.BUSY), wide_t'(expBusy));
    checkOutput("grantIdx", wide_t'(bus.GRANT_IDX), wide_t'(expGrant));
    checkOutput("pktCnt", wide_t'(bus.PKT_CNT), wide_t'(expPktCnt));
    expRdy = '0;
    if (expBusy && (outQ.size() == 0 || bus.M_TREADY)) expRdy[expGrant] = 1'b1;
    checkOutput("sReady", wide_t'(bus.S_TREADY), wide_t'(expRdy));
    checkOutput("mValid", wide_t'(bus.M_TVALID), wide_t'(outQ.size() != 0));
    if (outQ.size() != 0) begin
      checkOutput("mData", wide_t'(bus.M_TDATA), wide_t'(outQ[0].data));
      checkOutput("mLast", wide_t'(bus.M_TLAST), wide_t'(outQ[0].last));
      checkOutput("mId", wide_t'(bus.M_TID), wide_t'(outQ[0].id));
      checkOutput("mDest", wide_t'(bus.M_TDEST), wide_t'(outQ[0].dest));
      checkOutput("mUser", wide_t'(bus.M_TUSER), wide_t'(outQ[0].user));
    end
    outHs = (outQ.size() != 0) && bus.M_TREADY;
    inHs  = expBusy && bus.S_TVALID[expGrant] && (outQ.size() == 0 || bus.M_TREADY);
    if (!rstN) begin
      modelReset();
    end else begin
      if (outHs) void'(outQ.pop_front());
      if (inHs) begin
        beat_t b;
        b = srcQ[expGrant].pop_front();
        outQ.push_back(b);
        inHsCount++;
        if (b.last) begin
          expBusy   = 1'b0;
          expPtr    = (expGrant + 1) % NUM_REQ;
          expPktCnt = expPktCnt + 16'd1;
        end
      end else if (!expBusy) begin
        win = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
          int r;
          r = (expPtr + k) % NUM_REQ;
          if (win < 0 && bus.S_TVALID[r]) win = r;
        end
        if (win >= 0) begin
          expBusy  = 1'b1;
          expGrant = win;
        end
      end
    end
  endtask

  task automatic drain(input int maxCyc);
    int n;
    n = 0;
    while (pending() && n < maxCyc) begin
      applyStimulus();
      n++;
    end
    checkOutput("drainTimeout", wide_t'(pending()), wide_t'(0));
  endtask

  task automatic runUntilInHs(input int target);
    int n;
    n = 0;
    while (inHsCount < target && n < 200) begin
      applyStimulus();
      n++;
    end
    checkOutput("inHsTimeout", wide_t'(inHsCount >= target), wide_t'(1));
  endtask

  // Directed scenarios followed by random traffic.
  initial begin
    int startCyc, base, n;
    int exp41[6];
    exp41 = '{0, 0, 0, 0, 2, 2};

    rstN = 1'b0;
    bus.S_TVALID = '0; bus.S_TDATA = '0; bus.S_TLAST = '0;
    bus.S_TID = '0; bus.S_TDEST = '0; bus.S_TUSER = '0; bus.M_TREADY = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstBusy", wide_t'(bus.BUSY), 0);
    checkOutput("rstMValid", wide_t'(bus.M_TVALID), 0);
    checkOutput("rstPktCnt", wide_t'(bus.PKT_CNT), 0);
    checkOutput("rstGrant", wide_t'(bus.GRANT_IDX), 0);
    checkOutput("rstSReady", wide_t'(bus.S_TREADY), 0);
    checkOutput("rstMData", wide_t'(bus.M_TDATA), 0);
    checkOutput("rstMMeta", wide_t'({bus.M_TLAST, bus.M_TID, bus.M_TDEST, bus.M_TUSER}), 0);

    // Single 3-beat packet from requester 0.
    clearLogs();
    addPacket(0, 3, 1, 1'b0);
    startCyc = cyc + 1;
    drain(50);
    checkOutput("singleBeats", wide_t'(outLog.size()), 3);
    for (int k = 0; k < 3 && k < outLog.size(); k++) begin
      checkOutput("singleData", wide_t'(outLog[k].data), wide_t'(k + 1));
      checkOutput("singleCyc", wide_t'(outCyc[k]), wide_t'(startCyc + 2 + k));
    end
    checkOutput("singlePktCnt", wide_t'(bus.PKT_CNT), 1);

    // Round robin from index 0 with all requesters continuously valid.
    rstReq = 1'b1;
    applyStimulus();
    rstReq = 1'b0;
    clearLogs();
    for (int pk = 0; pk < 2; pk++)
      for (int r = 0; r < NUM_REQ; r++) addPacket(r, 2, 'h1000 * pk + 'h10 * r, 1'b0);
    drain(100);
    checkOutput("rrGrantCnt", wide_t'(grantLog.size() >= 5), 1);
    checkOutput("rrBeatCnt", wide_t'(outLog.size()), 16);
    if (grantLog.size() >= 5 && outLog.size() >= 10) begin
      for (int p = 0; p < 5; p++) begin
        checkOutput("rrGrant", wide_t'(grantLog[p]), wide_t'(p % 4));
        checkOutput("rrSrcA", wide_t'(outLog[2*p].id), wide_t'(p % 4));
        checkOutput("rrSrcB", wide_t'(outLog[2*p+1].id), wide_t'(p % 4));
        checkOutput("rrLast", wide_t'({outLog[2*p].last, outLog[2*p+1].last}), 1);
        checkOutput("rrInPkt", wide_t'(outCyc[2*p+1] - outCyc[2*p]), 1);
        if (p < 4) checkOutput("rrGap", wide_t'(outCyc[2*p+2] - outCyc[2*p+1]), 2);
      end
    end

    // Backpressure: injection port stalls for 5 cycles after two beats.
    clearLogs();
    addPacket(1, 6, 'h100, 1'b0);
    n = 0;
    while (outLog.size() < 2 && n < 50) begin applyStimulus(); n++; end
    checkOutput("bpReach", wide_t'(outLog.size()), 2);
    rdyLow = 1'b1;
    for (int k = 0; k < 5; k++) begin
      applyStimulus();
      checkOutput("bpHold", wide_t'(bus.M_TDATA), 'h102);
      checkOutput("bpValid", wide_t'(bus.M_TVALID), 1);
      checkOutput("bpReady", wide_t'(bus.S_TREADY), 0);
    end
    rdyLow = 1'b0;
    drain(50);
    checkOutput("bpBeats", wide_t'(outLog.size()), 6);
    for (int k = 0; k < 6 && k < outLog.size(); k++)
      checkOutput("bpData", wide_t'(outLog[k].data), wide_t'('h100 + k));
    for (int k = 3; k < 6 && k < outLog.size(); k++)
      checkOutput("bpRate", wide_t'(outCyc[k] - outCyc[k-1]), 1);

    // Bubble: granted requester 0 stalls while requester 2 waits.
    clearLogs();
    addPacket(0, 4, 'h200, 1'b0);
    applyStimulus();
    checkOutput("bubbleGrant0", wide_t'(expBusy && expGrant == 0), 1);
    addPacket(2, 2, 'h300, 1'b0);
    base = inHsCount;
    runUntilInHs(base + 2);
    holdLow[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      applyStimulus();
      checkOutput("bubbleGnt", wide_t'(bus.GRANT_IDX), 0);
      checkOutput("bubbleBusy", wide_t'(bus.BUSY), 1);
      checkOutput("bubbleRdy2", wide_t'(bus.S_TREADY[2]), 0);
    end
    holdLow[0] = 1'b0;
    drain(50);
    checkOutput("bubbleBeats", wide_t'(outLog.size()), 6);
    for (int k = 0; k < 6 && k < outLog.size(); k++)
      checkOutput("bubbleOrder", wide_t'(outLog[k].id), wide_t'(exp41[k]));

    // Packet counter wraps from 0xFFFF to 0.
    @(negedge clk);
    force dut.pktCnt_q = 16'hFFFF;
    #1;
    release dut.pktCnt_q;
    expPktCnt = 16'hFFFF;
    addPacket(1, 1, 'h400, 1'b0);
    drain(20);
    checkOutput("wrapCnt", wide_t'(bus.PKT_CNT), 0);

    // Reset after beat 2 of a 4-beat packet, then a clean packet from requester 3.
    addPacket(0, 4, 'h500, 1'b0);
    base = inHsCount;
    runUntilInHs(base + 2);
    rstReq = 1'b1;
    applyStimulus();
    rstReq = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midRstMValid", wide_t'(bus.M_TVALID), 0);
    checkOutput("midRstBusy", wide_t'(bus.BUSY), 0);
    checkOutput("midRstPktCnt", wide_t'(bus.PKT_CNT), 0);
    checkOutput("midRstMData", wide_t'(bus.M_TDATA), 0);
    clearLogs();
    addPacket(3, 2, 'h600, 1'b0);
    drain(30);
    checkOutput("postRstGrants", wide_t'(grantLog.size()), 1);
    if (grantLog.size() >= 1) checkOutput("postRstGrant", wide_t'(grantLog[0]), 3);
    checkOutput("postRstBeats", wide_t'(outLog.size()), 2);
    for (int k = 0; k < 2 && k < outLog.size(); k++)
      checkOutput("postRstData", wide_t'(outLog[k].data), wide_t'('h600 + k));

    // Random traffic with bubbles and backpressure.
    vldPct = 70;
    rdyPct = 60;
    for (int p = 0; p < 80; p++)
      addPacket($urandom_range(NUM_REQ - 1), $urandom_range(1, 5), 0, 1'b1);
    drain(5000);
    vldPct = 100;
    rdyPct = 100;

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule

// File: doc/mvm_noc_inject_arb.md
MVM_NOC_INJECT_ARB -- requirements
Module: mvm_noc_inject_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of AXI-Stream requesters (1..16).
REQ-002 SHALL have parameter DATAW, default 512: TDATA width.
REQ-003 SHALL have parameters IDW, DESTW and USERW, each default 8: TID, TDEST and TUSER widths.
REQ-004 SHALL use one clock, CLK; reset RST_N SHALL be synchronous and active-low.
REQ-005 SHALL have port CLK, input, 1 bit: single clock for all logic.
REQ-006 SHALL have port RST_N, input, 1 bit: synchronous active-low reset.
REQ-007 SHALL have port S_TVALID, input, NUM_REQ bits: per-requester valid.
REQ-008 SHALL have port S_TREADY, output, NUM_REQ bits: per-requester ready.
REQ-009 SHALL have port S_TDATA, input, NUM_REQ*DATAW bits: requester i occupies slice [i*DATAW +: DATAW].
REQ-010 SHALL have port S_TLAST, input, NUM_REQ bits: per-requester end-of-packet.
REQ-011 SHALL have ports S_TID, S_TDEST and S_TUSER, inputs, NUM_REQ*IDW, NUM_REQ*DESTW and NUM_REQ*USERW bits, sliced like S_TDATA.
REQ-012 SHALL have port M_TVALID, output, 1 bit, towards the NoC injection port.
REQ-013 SHALL have port M_TREADY, input, 1 bit, from the NoC injection port.
REQ-014 SHALL have ports M_TDATA, M_TLAST, M_TID, M_TDEST and M_TUSER, outputs, DATAW, 1, IDW, DESTW and USERW bits.
REQ-015 SHALL have port GRANT_IDX, output, $clog2(NUM_REQ) bits (minimum 1): current or last granted requester.
REQ-016 SHALL have port BUSY, output, 1 bit: packet in progress.
REQ-017 SHALL have port PKT_CNT, output, 16 bits: count of completed packets.

Function
REQ-018 SHALL implement two states: IDLE and LOCKED.
REQ-019 In IDLE, S_TREADY SHALL be all zero.
REQ-020 In IDLE with any S_TVALID high, the winner SHALL be the first asserted index searching upward from ptr with wrap-around; the block SHALL register GRANT_IDX=winner and enter LOCKED next cycle.
REQ-021 In LOCKED, S_TREADY[GRANT_IDX] SHALL equal (!M_TVALID || M_TREADY); all other S_TREADY bits SHALL be 0.
REQ-022 Arbitration SHALL be packet-granular: the grant SHALL not change until the beat with S_TLAST=1 handshakes on the granted port.
REQ-023 On the TLAST handshake the block SHALL return to IDLE, set ptr=(GRANT_IDX+1) mod NUM_REQ and increment PKT_CNT, wrapping 0xFFFF->0x0000.
REQ-024 Packet overhead SHALL be exactly one IDLE arbitration cycle between packets.
REQ-025 Within a packet, throughput SHALL be one beat per cycle while M_TREADY=1.
REQ-026 The output SHALL be a single register stage: on an input handshake, all M_* payload fields SHALL load from the granted slice and M_TVALID SHALL be 1 in the next cycle, giving 1-cycle latency.
REQ-027 M_TVALID SHALL clear when M_TREADY=1 and no new beat is loaded in the same cycle.
REQ-028 A simultaneous drain and load SHALL keep M_TVALID=1 with the new payload.
REQ-029 While M_TVALID=1 and M_TREADY=0, all M_* outputs SHALL hold stable.
REQ-030 If the granted requester deasserts S_TVALID mid-packet, the grant SHALL be held with no timeout and no beat injected.
REQ-031 Non-granted S_TVALID SHALL be ignored; no beat SHALL be lost or duplicated.
REQ-032 BUSY SHALL be 1 exactly when the state is LOCKED.
REQ-033 GRANT_IDX SHALL hold its last value in IDLE.
REQ-034 With NUM_REQ=1, the block SHALL pass packets through, with the same one-cycle inter-packet gap.

Reset
REQ-035 When RST_N=0 at a CLK edge, the state SHALL become IDLE and ptr, GRANT_IDX and PKT_CNT SHALL be 0.
REQ-036 When RST_N=0 at a CLK edge, M_TVALID and all M_* payload outputs SHALL be 0, and BUSY and S_TREADY SHALL be 0.
REQ-037 Reset mid-packet SHALL discard the packet, including any beat held in the output register; after reset, arbitration SHALL restart from index 0.

Verification
REQ-038 Single requester: req0 sends a 3-beat packet (data 0x1,0x2,0x3, TLAST on beat 3) with M_TREADY=1 -> M_TVALID high for 3 consecutive cycles starting 2 cycles after S_TVALID rises, data 0x1..0x3, PKT_CNT=1.
REQ-039 Round-robin: all 4 requesters continuously valid with 2-beat packets -> grant order 0,1,2,3,0; one gap cycle between packets; packets never interleave.
REQ-040 Backpressure: M_TREADY low for 5 cycles mid-packet -> M_* outputs stable, S_TREADY[g]=0 while the output is full, no beat lost; resumes at 1 beat/cycle.
REQ-041 Bubble: the granted requester drops S_TVALID for 3 cycles mid-packet while req2 is valid -> the grant is held, req2 is not served until the TLAST handshake.
REQ-042 Wrap: preset 65535 completed packets, then send 1 more -> PKT_CNT=0x0000.
REQ-043 Reset mid-packet: assert RST_N=0 after beat 2 of 4 -> M_TVALID=0, BUSY=0, PKT_CNT=0 next cycle; the next packet from req3 is granted cleanly.
